// File: rtl/arb_req_pkg.sv
// Shared constants for the arbiter requester: FSM encoding and default parameters.
package arb_req_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 4;
  localparam int DEF_CMD_DEPTH  = 4;
  localparam int DEF_TIMEOUT    = 255;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

endpackage

// File: rtl/arb_requester_if.sv
// Command, local-data, arbiter and shared-bus signals of one requester port.
interface arb_requester_if import arb_req_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  request;
  logic                  acknowledge;
  logic                  grant;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;
  logic                  busy;
  logic                  timeout;

  modport master (
    input  cmd_valid, cmd_len, s_data, s_valid, grant, m_ready,
    output cmd_ready, s_ready, request, acknowledge, m_data, m_valid, m_last, busy, timeout
  );

  modport slave (
    output cmd_valid, cmd_len, s_data, s_valid, grant, m_ready,
    input  cmd_ready, s_ready, request, acknowledge, m_data, m_valid, m_last, busy, timeout
  );
endinterface

// File: rtl/arb_req_fifo.sv
// Show-ahead command FIFO: head visible the cycle after a write; caller must not push when full
// (unless popping) nor pop when empty.
module arb_req_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr[AW-1:0]];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
endmodule

// File: rtl/arb_requester.sv
// Arbiter client: queued burst -> held request -> grant -> burst -> 1-cycle acknowledge; request 2 cycles
// after a command is offered, 1 beat/cycle, stalls on grant/m_ready. ARB_REQ_TIMEOUT_EN adds a grant watchdog.
module arb_requester import arb_req_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int CMD_DEPTH  = DEF_CMD_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic           clk,
  input logic           rst,
  arb_requester_if.master bus
);
  logic [1:0]           state;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [LEN_WIDTH-1:0] head_len;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 push;
  logic                 in_xfer;
  logic                 beat;
  logic                 request_q;
  logic                 ack_q;
  logic                 timeout_q;
  logic                 unused_cfg;

  // Data width is carried by the interface; the limit only matters with the watchdog.
  assign unused_cfg = (DATA_WIDTH != 0) | (TIMEOUT != 0);

  assign pop     = (state == ST_IDLE) && !fifo_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign bus.cmd_ready = !fifo_full || pop;
  assign push    = bus.cmd_valid && bus.cmd_ready;

  arb_req_fifo #(
    .WIDTH (LEN_WIDTH),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_dat (bus.cmd_len),
    .pop    (pop),
    .rd_dat (head_len),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign in_xfer     = (state == ST_XFER);
  assign bus.m_valid = in_xfer && bus.s_valid && bus.grant;
  assign bus.s_ready = in_xfer && bus.m_ready && bus.grant;
  assign bus.m_data  = bus.s_data;
  assign bus.m_last  = in_xfer && (beat_cnt == len_reg);
  assign beat        = bus.m_valid && bus.m_ready;

  assign bus.request     = request_q;
  assign bus.acknowledge = ack_q;
  assign bus.busy        = (state != ST_IDLE) || !fifo_empty;
  assign bus.timeout     = timeout_q;

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      request_q <= 1'b0;
      ack_q     <= 1'b0;
      len_reg   <= '0;
      beat_cnt  <= '0;
      timeout_q <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            len_reg   <= head_len;
            beat_cnt  <= '0;
            request_q <= 1'b1;
            state     <= ST_REQ;
`ifdef ARB_REQ_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (bus.grant) begin
            state <= ST_XFER;
`ifdef ARB_REQ_TIMEOUT_EN
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            // Expiry drops the command; grant on the same edge takes priority above.
            timeout_q <= 1'b1;
            request_q <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        ST_XFER: begin
          if (beat) begin
            if (beat_cnt == len_reg) begin
              request_q <= 1'b0;
              ack_q     <= 1'b1;
              state     <= ST_ACK;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          ack_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: transaction-level model compared every cycle plus literal checks.
module tb_arb_requester;
  import arb_req_pkg::*;

  localparam int DW    = 32;
  localparam int LW    = 4;
  localparam int DEPTH = 4;
  localparam int TO    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb_requester_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  arb_requester #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .CMD_DEPTH  (DEPTH),
    .TIMEOUT    (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: queue of pending bursts plus what the port currently owns.
  int mq[$];
  bit have;       // holding a burst (requesting or transferring)
  bit granted;    // grant has been seen for the held burst
  bit ack_cyc;    // release cycle
  bit to_pulse;
  int left;       // beats still owed on the held burst
  int waited;
  bit pop_n, push_n, beat_n;

  function automatic bit m_pop();
    return !have && !ack_cyc && (mq.size() > 0);
  endfunction
  function automatic bit exp_cmd_ready();
    return (mq.size() < DEPTH) || m_pop();
  endfunction
  function automatic bit exp_m_valid();
    return have && granted && bus.s_valid && bus.grant;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      have = 0; granted = 0; ack_cyc = 0; to_pulse = 0; left = 0; waited = 0;
    end else begin
      pop_n  = m_pop();
      push_n = bus.cmd_valid && exp_cmd_ready();
      beat_n = exp_m_valid() && bus.m_ready;
      to_pulse = 0;
      if (ack_cyc) ack_cyc = 0;
      else if (pop_n) begin
        left = mq.pop_front() + 1;
        have = 1; granted = 0; waited = 0;
      end else if (have && !granted) begin
        if (bus.grant) granted = 1;
`ifdef ARB_REQ_TIMEOUT_EN
        else if (waited + 1 == TO) begin
          have = 0; to_pulse = 1;
        end
`endif
        else waited++;
      end else if (have && beat_n) begin
        left--;
        if (left == 0) begin
          have = 0; granted = 0; ack_cyc = 1;
        end
      end
      if (push_n) mq.push_back(int'(bus.cmd_len));
    end
  end

  always @(negedge clk) begin
    chk("request", bus.request, have);
    chk("acknowledge", bus.acknowledge, ack_cyc);
    chk("m_valid", bus.m_valid, exp_m_valid());
    chk("s_ready", bus.s_ready, have && granted && bus.m_ready && bus.grant);
    chk("m_last", bus.m_last, have && granted && (left == 1));
    chk("busy", bus.busy, have || ack_cyc || (mq.size() > 0));
    chk("cmd_ready", bus.cmd_ready, exp_cmd_ready());
    chk("timeout", bus.timeout, to_pulse);
    if (exp_m_valid()) chk("m_data", bus.m_data, bus.s_data);
  end

  // Observation counters for the literal checks.
  int mon_beats, mon_last_idx, mon_acks, mon_tos, mon_falls, mon_pushes, mon_req_ack;
  int cur_burst, low_run, rise_cyc, to_cyc, to_req;
  bit prev_req, seen_req;
  int bursts[$];
  int gaps[$];

  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) begin
      mon_beats++;
      cur_burst++;
      if (bus.m_last) begin
        mon_last_idx = mon_beats;
        bursts.push_back(cur_burst);
        cur_burst = 0;
      end
    end
    if (bus.acknowledge) mon_acks++;
    if (bus.acknowledge && bus.request) mon_req_ack++;
    if (bus.timeout) begin
      mon_tos++; to_cyc = cyc; to_req = int'(bus.request);
    end
    if (bus.request && !prev_req) begin
      rise_cyc = cyc;
      if (seen_req) gaps.push_back(low_run);
      seen_req = 1;
    end
    if (!bus.request && prev_req) mon_falls++;
    low_run = bus.request ? 0 : low_run + 1;
    if (bus.cmd_valid && bus.cmd_ready) mon_pushes++;
    prev_req = bus.request;
  end

  task automatic mon_clear();
    mon_beats = 0; mon_last_idx = 0; mon_acks = 0; mon_tos = 0; mon_falls = 0;
    mon_pushes = 0; mon_req_ack = 0; cur_burst = 0; low_run = 0;
    rise_cyc = 0; to_cyc = 0; to_req = 0;
    prev_req = bus.request; seen_req = 0;
    bursts.delete(); gaps.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.s_data = $urandom;
  endtask

  task automatic push_cmd(input int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(len);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!bus.request && n < budget) begin tick(); n++; end
    chk("request_rise_budget", bus.request, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin tick(); n++; end
    chk("idle_budget", bus.busy, 0);
  endtask

  task automatic wait_beats(input int nb, input int budget);
    int n = 0;
    while (mon_beats < nb && n < budget) begin tick(); n++; end
    chk("beat_budget", mon_beats, nb);
  endtask

  int t0;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.s_data = '0;
    bus.s_valid = 1'b1; bus.m_ready = 1'b1; bus.grant = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_request", bus.request, 0);
    chk("rst_ack", bus.acknowledge, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    rst = 1'b0; bus.grant = 1'b0;
    tick();

    // Single burst of 4, grant two cycles after request.
    mon_clear();
    t0 = cyc;
    push_cmd(3);
    chk("req_not_yet", bus.request, 0);
    wait_req(5);
    chk("cmd_to_req", cyc - t0, 2);
    tick(); tick();
    bus.grant = 1'b1;
    wait_idle(40);
    bus.grant = 1'b0;
    chk("single_beats", mon_beats, 4);
    chk("single_last_idx", mon_last_idx, 4);
    chk("single_acks", mon_acks, 1);
    chk("single_req_during_ack", mon_req_ack, 0);

    // Grant dropped for 3 cycles after beat 2 of 8.
    mon_clear();
    push_cmd(7);
    wait_req(5);
    bus.grant = 1'b1;
    wait_beats(2, 20);
    bus.grant = 1'b0;
    repeat (3) tick();
    chk("gap_no_beats", mon_beats, 2);
    bus.grant = 1'b1;
    wait_idle(40);
    bus.grant = 1'b0;
    chk("gap_beats", mon_beats, 8);
    chk("gap_last_idx", mon_last_idx, 8);
    chk("gap_req_falls", mon_falls, 1);

    // Back-to-back lengths 0,1,2 with grant held.
    mon_clear();
    bus.grant = 1'b1;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_len = LW'(i);
      tick();
    end
    bus.cmd_valid = 1'b0;
    wait_idle(60);
    bus.grant = 1'b0;
    chk("b2b_bursts", bursts.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < bursts.size()) chk("b2b_burst_len", bursts[i], i + 1);
    chk("b2b_gaps", gaps.size(), 2);
    for (int i = 0; i < 2; i++)
      if (i < gaps.size()) chk("b2b_req_low", gaps[i], 2);

    // Fill the FIFO while grant is low, then push into a full FIFO as it pops.
    mon_clear();
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_len = LW'(i);
      tick();
    end
    bus.cmd_valid = 1'b0;
    chk("full_pushes", mon_pushes, 5);
    chk("full_cmd_ready", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(5);
    bus.grant     = 1'b1;
    for (int n = 0; n < 30 && mon_pushes < 6; n++) tick();
    bus.cmd_valid = 1'b0;
    chk("full_push_pop", mon_pushes, 6);
    wait_idle(100);
    bus.grant = 1'b0;
    chk("full_total_beats", mon_beats, 21);
    chk("full_bursts", bursts.size(), 6);

    // Reset after beat 1 of 4 with another command queued.
    mon_clear();
    push_cmd(3);
    push_cmd(2);
    bus.grant = 1'b1;
    wait_beats(1, 20);
    rst = 1'b1;
    tick();
    chk("rstx_request", bus.request, 0);
    chk("rstx_ack", bus.acknowledge, 0);
    chk("rstx_busy", bus.busy, 0);
    chk("rstx_cmd_ready", bus.cmd_ready, 1);
    rst = 1'b0;
    repeat (5) tick();
    chk("rstx_discarded_req", bus.request, 0);
    chk("rstx_discarded_busy", bus.busy, 0);
    bus.grant = 1'b0;

`ifdef ARB_REQ_TIMEOUT_EN
    // Grant never comes: expiry 10 cycles after request, command dropped.
    mon_clear();
    push_cmd(1);
    wait_req(5);
    for (int n = 0; n < 30 && mon_tos == 0; n++) tick();
    chk("to_pulses", mon_tos, 1);
    chk("to_delay", to_cyc - rise_cyc, 10);
    chk("to_req_dropped", to_req, 0);
    repeat (4) tick();
    chk("to_discarded_busy", bus.busy, 0);
    chk("to_no_beats", mon_beats, 0);
    chk("to_single_pulse", mon_tos, 1);

    // Grant on the 10th cycle wins over expiry.
    mon_clear();
    push_cmd(1);
    wait_req(5);
    repeat (9) tick();
    bus.grant = 1'b1;
    wait_idle(30);
    bus.grant = 1'b0;
    chk("to_race_no_pulse", mon_tos, 0);
    chk("to_race_beats", mon_beats, 2);
`else
    // Without the watchdog a request waits indefinitely.
    mon_clear();
    push_cmd(1);
    wait_req(5);
    repeat (20) tick();
    chk("nowd_req_held", bus.request, 1);
    chk("nowd_no_pulse", mon_tos, 0);
    bus.grant = 1'b1;
    wait_idle(30);
    bus.grant = 1'b0;
    chk("nowd_beats", mon_beats, 2);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
